// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control FSM with memory wait timeout and retired-instruction counter.
// Latency: outputs are a function of the current state (plus mem_ready/Zero gating of PCWrite/IRWrite).
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; WAIT_LIMIT consecutive stalls force HALT.
module mc_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             halted,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Wide enough to hold WAIT_LIMIT itself so the compare below never truncates.
    localparam int WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
    logic [5:0]          op_q, op_d;
    logic [1:0]          err_q, err_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                retire;
    logic                timeout;
    logic                in_wait_state;

    // Timeout fires on the stall cycle whose increment would bring the counter to
    // WAIT_LIMIT, so a state sees exactly WAIT_LIMIT not-ready cycles before HALT.
    // A mem_ready in that same cycle takes priority in the next-state logic.
    always_comb begin
        wait_inc      = wait_q + WAIT_W'(1);
        timeout       = (wait_inc == WAIT_W'(WAIT_LIMIT)) && !mem_ready;
        in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    end

    // Next-state, opcode latch, error code and retire strobe.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                op_d = OpCode;
                case (OpCode)
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDIEX;
                    default: begin
                        state_d = S_HALT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            // Load/store choice comes from the opcode captured in DECODE, not the live bus.
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Wait counter: zero whenever the state changes, counts stall cycles while waiting.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait_state && !mem_ready) begin
            wait_d = wait_inc;
        end
    end

    // Retired counter wraps naturally at 2^CNT_W.
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State, counters and latched opcode; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            op_q      <= '0;
            err_q     <= ERR_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    // Moore control decode; only PCWrite/IRWrite look at live inputs.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        halted   = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCWrite  = (op_q == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign state    = state_q;
    assign err_code = err_q;
    assign retired  = retired_q;

endmodule
